map_query_arbiter: RTL and testbench

Shares the single combinational wall-lookup map between the Pac-Man mover and the ghost movers. Each requester posts its current tile position and intended direction; the arbiter grants one requester at a time round-robin, computes the neighbouring tile coordinate, drives it to the map, and returns a one-cycle "path free" answer to the granted requester. It sits between the movement controllers and the `Map` instance, replacing per-mover private map copies.

---
 rtl/map_query_arbiter_if.sv | 36 +++
 rtl/map_query_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_map_query_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/map_query_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : map_query_arbiter_if
// Brief    : Requester/map bus between the movers, the arbiter and the Map.
// Revision : 1.0 - initial release
// ============================================================================
interface map_query_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [N_REQ*10-1:0] pos_x;
  logic [N_REQ*9-1:0]  pos_y;
  logic [N_REQ*2-1:0]  dir;
  logic [9:0]          map_x;
  logic [8:0]          map_y;
  logic                map_is_wall;
  logic [N_REQ-1:0]    ack;
  logic                free;
  logic [ID_W-1:0]     resp_id;
  logic                busy;

  // Arbiter side.
  modport slave (
    input  req, pos_x, pos_y, dir, map_is_wall,
    output map_x, map_y, ack, free, resp_id, busy
  );

  // Requester / map side.
  modport master (
    output req, pos_x, pos_y, dir, map_is_wall,
    input  map_x, map_y, ack, free, resp_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/map_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : map_query_arbiter
// Brief    : Round-robin sharing of one wall-lookup map among movers.
//            Optional macro MAP_BOUND_CHECK_EN: out-of-range targets read as blocked.
// Revision : 1.0 - initial release
// ============================================================================
module map_query_arbiter #(
  parameter int N_REQ = 4,
  parameter int STEP  = 32,
  parameter int X_MAX = 640,
  parameter int Y_MAX = 480
) (
  input  logic                clk,
  input  logic                rst,
  map_query_arbiter_if.slave  bus
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOOKUP = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam logic [9:0]       STEP_X   = 10'(STEP);
  localparam logic [8:0]       STEP_Y   = 9'(STEP);
  localparam logic [10:0]      X_LIM    = 11'(X_MAX);
  localparam logic [9:0]       Y_LIM    = 10'(Y_MAX);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

`ifdef MAP_BOUND_CHECK_EN
  localparam logic BOUND_CHECK = 1'b1;
`else
  localparam logic BOUND_CHECK = 1'b0;
`endif

  logic [1:0]       state_q,   state_d;
  logic [ID_W-1:0]  grant_q,   grant_d;
  logic [ID_W-1:0]  last_q,    last_d;
  logic [9:0]       map_x_q,   map_x_d;
  logic [8:0]       map_y_q,   map_y_d;
  logic             oob_q,     oob_d;
  logic [N_REQ-1:0] ack_q,     ack_d;
  logic             free_q,    free_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;

  logic [N_REQ-1:0][9:0] tgt_x;
  logic [N_REQ-1:0][8:0] tgt_y;
  logic [N_REQ-1:0]      tgt_oob;

  logic             pick_valid;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  cand;

  // Neighbour tile for every requester, computed in parallel and muxed at grant.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_tgt
    logic [9:0] px;
    logic [8:0] py;
    logic [1:0] pd;
    logic [9:0] tx;
    logic [8:0] ty;
    logic       oob;

    assign px = bus.pos_x[gi*10 +: 10];
    assign py = bus.pos_y[gi*9 +: 9];
    assign pd = bus.dir[gi*2 +: 2];

    always_comb begin
      tx  = px;
      ty  = py;
      oob = 1'b0;
      case (pd)
        DIR_UP: begin
          ty  = py - STEP_Y;
          oob = (py < STEP_Y);
        end
        DIR_DOWN: begin
          ty  = py + STEP_Y;
          oob = (({1'b0, py} + {1'b0, STEP_Y}) >= Y_LIM);
        end
        DIR_LEFT: begin
          tx  = px - STEP_X;
          oob = (px < STEP_X);
        end
        default: begin
          tx  = px + STEP_X;
          oob = (({1'b0, px} + {1'b0, STEP_X}) >= X_LIM);
        end
      endcase
    end

    assign tgt_x[gi]   = tx;
    assign tgt_y[gi]   = ty;
    assign tgt_oob[gi] = oob;
  end

  // Search begins just past the last winner, so a repeat requester goes last.
  always_comb begin
    pick_valid = 1'b0;
    pick       = last_q;
    cand       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % N_REQ);
      if (!pick_valid && bus.req[cand]) begin
        pick_valid = 1'b1;
        pick       = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    map_x_d   = map_x_q;
    map_y_d   = map_y_q;
    oob_d     = oob_q;
    ack_d     = '0;
    free_d    = free_q;
    resp_id_d = resp_id_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          map_x_d = tgt_x[pick];
          map_y_d = tgt_y[pick];
          oob_d   = tgt_oob[pick];
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        free_d    = ~bus.map_is_wall & ~(BOUND_CHECK & oob_q);
        ack_d     = ONE_HOT0 << grant_q;
        resp_id_d = grant_q;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      last_q    <= LAST_RST;
      map_x_q   <= '0;
      map_y_q   <= '0;
      oob_q     <= 1'b0;
      ack_q     <= '0;
      free_q    <= 1'b0;
      resp_id_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      map_x_q   <= map_x_d;
      map_y_q   <= map_y_d;
      oob_q     <= oob_d;
      ack_q     <= ack_d;
      free_q    <= free_d;
      resp_id_q <= resp_id_d;
    end
  end

  assign bus.map_x   = map_x_q;
  assign bus.map_y   = map_y_q;
  assign bus.ack     = ack_q;
  assign bus.free    = free_q;
  assign bus.resp_id = resp_id_q;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_map_query_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_query_arbiter
// Brief    : Directed self-checking bench for map_query_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_query_arbiter;
  localparam int N_REQ = 4;
`ifdef MAP_BOUND_CHECK_EN
  localparam int OOB_FREE = 0;
`else
  localparam int OOB_FREE = 1;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  map_query_arbiter_if #(.N_REQ(N_REQ)) bus ();

  map_query_arbiter #(
    .N_REQ (N_REQ),
    .STEP  (32),
    .X_MAX (640),
    .Y_MAX (480)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tiny map: walls only at (128,64) and (320,224).
  assign bus.map_is_wall = ((bus.map_x == 10'd128) && (bus.map_y == 9'd64)) ||
                           ((bus.map_x == 10'd320) && (bus.map_y == 9'd224));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int x, input int y, input int d);
    bus.pos_x[i*10 +: 10] = 10'(x);
    bus.pos_y[i*9 +: 9]   = 9'(y);
    bus.dir[i*2 +: 2]     = 2'(d);
    bus.req[i]            = 1'b1;
  endtask

  task automatic expect_ack(input int id, input int ex, input int ey, input int ef);
    int n;
    n = 0;
    while (bus.ack == '0 && n < 12) begin
      tick();
      n++;
    end
    if (bus.ack == '0) begin
      chk("ack_timeout", 32'd0, 32'd1);
    end else begin
      chk("ack",     32'(bus.ack),     32'(1 << id));
      chk("resp_id", 32'(bus.resp_id), 32'(id));
      chk("free",    32'(bus.free),    32'(ef));
      chk("map_x",   32'(bus.map_x),   32'(ex));
      chk("map_y",   32'(bus.map_y),   32'(ey));
      bus.req[id] = 1'b0;
      tick();
      chk("ack_clear", 32'(bus.ack), 32'd0);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int extra;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    bus.req = '0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    bus.dir   = '0;
    tick();
    tick();

    chk("rst_ack",     32'(bus.ack),     32'd0);
    chk("rst_free",    32'(bus.free),    32'd0);
    chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
    chk("rst_map_x",   32'(bus.map_x),   32'd0);
    chk("rst_map_y",   32'(bus.map_y),   32'd0);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    rst = 1'b0;
    tick();

    // Exact cycle timing of a single query.
    set_req(0, 64, 64, 3);
    tick();
    chk("t1_map_x", 32'(bus.map_x), 32'd96);
    chk("t1_map_y", 32'(bus.map_y), 32'd64);
    chk("t1_busy",  32'(bus.busy),  32'd1);
    chk("t1_ack0",  32'(bus.ack),   32'd0);
    tick();
    chk("t1_ack",     32'(bus.ack),     32'b0001);
    chk("t1_free",    32'(bus.free),    32'd1);
    chk("t1_resp_id", 32'(bus.resp_id), 32'd0);
    bus.req[0] = 1'b0;
    tick();
    chk("t1_ack_end",  32'(bus.ack),  32'd0);
    chk("t1_busy_end", 32'(bus.busy), 32'd0);

    // Walls and plain moves.
    set_req(1, 128, 96, 0);  expect_ack(1, 128, 64, 0);
    set_req(3, 320, 256, 0); expect_ack(3, 320, 224, 0);
    set_req(2, 200, 100, 1); expect_ack(2, 200, 132, 1);

    // Edges of the playfield.
    set_req(0, 0, 0, 2);     expect_ack(0, 992, 0, OOB_FREE);
    set_req(1, 608, 0, 3);   expect_ack(1, 640, 0, OOB_FREE);
    set_req(2, 32, 448, 1);  expect_ack(2, 32, 480, OOB_FREE);
    set_req(3, 32, 32, 0);   expect_ack(3, 32, 0, 1);
    set_req(0, 576, 0, 3);   expect_ack(0, 608, 0, 1);
    set_req(1, 32, 416, 1);  expect_ack(1, 32, 448, 1);

    // Round-robin with all four requesting continuously.
    pulse_reset();
    for (int i = 0; i < N_REQ; i++) set_req(i, 64 * (i + 1), 64, 3);
    n = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (bus.ack != '0) begin
        chk("rr_ack",     32'(bus.ack),     32'(1 << (n % N_REQ)));
        chk("rr_resp_id", 32'(bus.resp_id), 32'(n % N_REQ));
        chk("rr_map_x",   32'(bus.map_x),   32'(96 + 64 * (n % N_REQ)));
        n++;
      end
    end
    chk("rr_count", 32'(n), 32'd5);
    bus.req = '0;
    tick();
    tick();
    tick();

    // Requester 0 was served last, so 1 goes first.
    set_req(0, 64, 128, 1);
    set_req(1, 96, 128, 1);
    expect_ack(1, 96, 160, 1);
    expect_ack(0, 64, 160, 1);

    // Drop and input change during LOOKUP do not cancel or alter the query.
    set_req(2, 64, 200, 1);
    tick();
    bus.req[2] = 1'b0;
    bus.pos_x[20 +: 10] = 10'd500;
    bus.dir[4 +: 2]     = 2'b00;
    expect_ack(2, 64, 232, 1);
    extra = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.ack != '0) extra++;
    end
    chk("late_single", 32'(extra), 32'd0);

    // Asynchronous reset in LOOKUP drops the query.
    set_req(1, 64, 64, 3);
    tick();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_ack",     32'(bus.ack),     32'd0);
    chk("mid_busy0",   32'(bus.busy),    32'd0);
    chk("mid_map_x",   32'(bus.map_x),   32'd0);
    chk("mid_map_y",   32'(bus.map_y),   32'd0);
    chk("mid_free",    32'(bus.free),    32'd0);
    chk("mid_resp_id", 32'(bus.resp_id), 32'd0);
    bus.req = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("mid_no_ack", 32'(bus.ack), 32'd0);
    set_req(3, 64, 64, 1);
    expect_ack(3, 64, 96, 1);

    pulse_reset();
    set_req(0, 64, 64, 3);
    set_req(3, 256, 64, 2);
    expect_ack(0, 96, 64, 1);
    expect_ack(3, 224, 64, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
